uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter: the responder end of the CPU's byte store to the console address 0x1000_0000. It accepts one-cycle write strobes carrying the store data, buffers bytes in a small FIFO, and serializes them as 8N1 frames on `tx`. It sits beside the data RAM and is driven by the CPU's UART write-enable and UART write-data outputs.

---
 rtl/uart_tx_if.sv | 20 ++
 rtl/uart_tx_mmio.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// CPU-to-console bus: byte-store strobe and data toward the UART, serial line and status back.
interface uart_tx_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;

    modport master (
        output wr_en, wr_data,
        input  tx, busy, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output tx, busy, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte stores are queued in a small FIFO and sent as 8N1 frames.
module uart_tx_mmio #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_if.slave   bus
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               ovf_q, ovf_d;

    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               push_c;
    logic               drop_c;
    logic               pop_c;
    logic               baud_last_c;
    logic               unused_wr_hi_c;

    assign unused_wr_hi_c = ^bus.wr_data[31:8];

    // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a write.
    assign push_c      = bus.wr_en && !full_q;
    assign drop_c      = bus.wr_en && full_q;
    assign baud_last_c = (baud_q == BAUD_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.wr_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop_c   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more bytes are queued.
                if (baud_last_c) begin
                    baud_d = '0;
                    if (!empty_q) begin
                        pop_c   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ovf_d   = ovf_q | drop_c;
        full_d  = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d = (count_d == '0);
        busy_d  = (state_d != IDLE) || (count_d != '0);

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_empty = empty_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=8; expected line levels are hand-derived.
module tb_uart_tx_mmio;

    localparam int unsigned DIV = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    uart_tx_if bus ();

    uart_tx_mmio #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle write strobe captured at the next rising edge.
    task automatic wr(input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Called just after the capture edge k; checks tx after edges k+first .. k+40.
    task automatic check_frame(input logic [7:0] b, input int first);
        int  pos;
        logic exp;
        for (int i = first; i <= 10 * DIV; i++) begin
            tick();
            pos = (i - 1) / DIV;
            if (pos == 0)      exp = 1'b0;
            else if (pos == 9) exp = 1'b1;
            else               exp = b[pos-1];
            check($sformatf("tx_b%02h_c%0d", b, i), 32'(bus.tx), 32'(exp));
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        repeat (3) tick();

        check("rst_tx",    32'(bus.tx),         32'd1);
        check("rst_busy",  32'(bus.busy),       32'd0);
        check("rst_full",  32'(bus.fifo_full),  32'd0);
        check("rst_empty", 32'(bus.fifo_empty), 32'd1);
        check("rst_ovf",   32'(bus.overflow),   32'd0);
        rst_n = 1'b1;
        tick();

        // Single byte 0x55
        wr(32'h0000_0055);
        check("sb_tx_k",    32'(bus.tx),         32'd1);
        check("sb_empty_k", 32'(bus.fifo_empty), 32'd0);
        check("sb_busy_k",  32'(bus.busy),       32'd1);
        check_frame(8'h55, 1);
        check("sb_busy_40", 32'(bus.busy), 32'd1);
        tick();
        check("sb_busy_41", 32'(bus.busy), 32'd0);
        check("sb_tx_41",   32'(bus.tx),   32'd1);

        // Upper store bits ignored
        wr(32'h1234_56A5);
        check_frame(8'hA5, 1);
        tick();
        check("ub_busy",  32'(bus.busy),       32'd0);
        check("ub_empty", 32'(bus.fifo_empty), 32'd1);
        check("ub_ovf",   32'(bus.overflow),   32'd0);

        // Back-to-back frames
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'h01;
        tick();
        bus.wr_data = 32'h02;
        tick();
        check("bb_tx_1", 32'(bus.tx), 32'd0);
        bus.wr_data = 32'h03;
        tick();
        check("bb_tx_2", 32'(bus.tx), 32'd0);
        bus.wr_en = 1'b0;
        check_frame(8'h01, 3);
        check_frame(8'h02, 1);
        check("bb_empty_pre", 32'(bus.fifo_empty), 32'd0);
        check_frame(8'h03, 1);
        check("bb_empty_post", 32'(bus.fifo_empty), 32'd1);
        check("bb_busy_120",   32'(bus.busy),       32'd1);
        tick();
        check("bb_busy_121", 32'(bus.busy), 32'd0);

        // Overflow: ten consecutive writes, ninth fills, tenth dropped
        for (int i = 0; i < 10; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 32'(i);
            tick();
            if (i == 7) check("ov_full_w8", 32'(bus.fifo_full), 32'd0);
            if (i == 8) begin
                check("ov_full_w9", 32'(bus.fifo_full), 32'd1);
                check("ov_ovf_w9",  32'(bus.overflow),  32'd0);
            end
        end
        bus.wr_en = 1'b0;
        check("ov_ovf_w10",  32'(bus.overflow),  32'd1);
        check("ov_full_w10", 32'(bus.fifo_full), 32'd1);
        check_frame(8'h00, 10);
        for (int i = 1; i <= 8; i++) begin
            check_frame(8'(i), 1);
        end
        tick();
        check("ov_busy_end", 32'(bus.busy),     32'd0);
        check("ov_tx_end",   32'(bus.tx),       32'd1);
        check("ov_ovf_end",  32'(bus.overflow), 32'd1);

        // Reset mid-frame during DATA of the first queued byte
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'h00;
        tick();
        bus.wr_data = 32'hFF;
        tick();
        bus.wr_data = 32'h0F;
        tick();
        bus.wr_en = 1'b0;
        repeat (10) tick();
        check("rm_tx_data", 32'(bus.tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rm_tx_async",   32'(bus.tx),   32'd1);
        check("rm_busy_async", 32'(bus.busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        check("rm_empty", 32'(bus.fifo_empty), 32'd1);
        check("rm_full",  32'(bus.fifo_full),  32'd0);
        check("rm_ovf",   32'(bus.overflow),   32'd0);
        for (int i = 0; i < 50; i++) begin
            tick();
            check($sformatf("rm_idle_%0d", i), {30'd0, bus.tx, bus.busy}, 32'd2);
        end

        // Pointer wrap-around: 20 spaced single writes
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'(i * 37 + 11);
            wr(32'(b));
            check_frame(b, 1);
            tick();
            check($sformatf("wr_ovf_%0d", i), 32'(bus.overflow), 32'd0);
        end
        check("wr_empty", 32'(bus.fifo_empty), 32'd1);
        check("wr_busy",  32'(bus.busy),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
